page_scheduler: RTL and testbench
=================================

# page_scheduler

Top-level sequencer for the piano's page modules. Each page (init, menu, free play, auto play, learn) drives a ProgramOutput. page_scheduler tracks the active TopState and routes user input only to the active page. It muxes the active page's text/seg to the display and performs a clean switch (blank, reset target page, settle) when the active page requests a new state. It sits between the input decoder, the page modules and the display/segment drivers.

## Interface
Parameters:
- NUM_PAGES, 5, number of page slots; slot index = TopState encoding
- BLANK_CYCLES, 4, display-blank cycles per switch; must be ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- user_in  in  UserInput  decoded user input
- page_out  in  ProgramOutput [NUM_PAGES]  outputs of every page module
- page_user_in  out  UserInput [NUM_PAGES]  per-page gated input; all-zero for non-active pages
- page_rst  out  logic [NUM_PAGES]  per-page synchronous reset pulse
- disp_out  out  ProgramOutput  registered text/seg/state to display drivers
- cur_state  out  TopState  active page
- switching  out  1  high while not in RUN
- bad_req  out  1  one-cycle pulse on out-of-range state request

## Operation
- Phases: RUN, BLANK, KICK, SETTLE.
- Reset values:
  - phase=KICK, tgt=INIT, cur_state=INIT, kick_all=1
  - page_rst=all-ones, switching=1, bad_req=0, armed=0
  - disp_out.text all spaces, disp_out.seg "        ", disp_out.state=INIT
- KICK:
  - kick_all=1: page_rst=all-ones for 1 cycle, then kick_all clears.
  - Otherwise: page_rst one-hot at tgt for 1 cycle.
  - Next phase is SETTLE.
- SETTLE: page_rst=0 for 1 cycle. Then cur_state<=tgt, armed<=0, phase RUN.
- RUN:
  - disp_out<=page_out[cur_state] every cycle.
  - page_user_in[cur_state]=user_in only when armed=1; all other entries are zero.
  - armed sets on the first RUN cycle with user_in.arrow_keys==0. This is the key-release lockout: the press that caused a switch never leaks into the new page.
- Request: in RUN, r=page_out[cur_state].state.
  - r==cur_state: no action.
  - r≥NUM_PAGES: bad_req pulse, stay in RUN.
  - Otherwise: tgt<=r, cnt<=BLANK_CYCLES-1, phase BLANK.
- BLANK:
  - disp_out is blank (reset value, with state=cur_state).
  - All page_user_in are zero.
  - cnt decrements each cycle; at cnt==0 the next phase is KICK.
- Ignored events:
  - state requests from non-active pages
  - any request while not in RUN (tgt is frozen once latched)
- Page contract: after its page_rst, page i must report page_out[i].state==i until it requests a change.
- rst asserted mid-switch: every register returns to its reset value immediately. The sequence restarts with kick_all.

## Timing
- Request visible at cycle t: switching=1 and BLANK from t+1.
- BLANK spans BLANK_CYCLES cycles, followed by KICK for 1 cycle and SETTLE for 1 cycle.
- cur_state changes at the end of SETTLE. Total non-RUN time is BLANK_CYCLES+2 cycles.
- disp_out shows the new page's output 1 cycle after RUN is entered; steady-state latency page_out to disp_out is 1 cycle.
- page_user_in is combinational from user_in, armed and cur_state (0-cycle latency).
- After reset deassert: KICK(all), then SETTLE, then RUN(INIT) from cycle 2.
- cnt width: $clog2(BLANK_CYCLES+1).

## Structure
- Shared package (header.svh):
  - TopState enum (INIT=0, MENU, FREE_PLAY, AUTO_PLAY, LEARN), sized to index page_out
  - UserInput, ProgramOutput, ScreenText types
  - BLANK_TEXT and BLANK_SEG constants
  - `RIGHT key code
- Local phase enum stays local to the module.
- No sub-module needed. An optional page_mux (pure ProgramOutput selector) can be split out if reused.

## Test plan
- Reset release: page_rst all-ones for 1 cycle, then 0; disp_out blank; cur_state==INIT and switching==0 from cycle 2.
- INIT page requests MENU at t: switching=1 at t+1; blank for 4 cycles; page_rst==5'b00010 for 1 cycle; cur_state==MENU after SETTLE; disp_out shows MENU text 1 cycle later.
- Key lockout: RIGHT held across the switch gives page_user_in[MENU]==0 until arrow_keys==0, then it passes through.
- Inactive FREE_PLAY page drives state=LEARN while MENU is active: no switch, switching stays 0.
- Active page requests state 7 (≥NUM_PAGES): bad_req pulses 1 cycle; cur_state unchanged.
- rst asserted during BLANK: outputs at reset values immediately; full reset sequence restarts; no stale tgt is committed.

Source files
------------

// File: rtl/page_scheduler_pkg.sv
// Shared types for the piano page sequencer.
// Provides the top-level state encoding, the decoded user-input record, the per-page
// output record (screen text, seven-segment text, requested state) and the blank display
// constants used while switching pages.
package page_scheduler_pkg;

  localparam int unsigned StateW = 3;

  // Page slot index equals the state encoding.
  typedef enum logic [StateW-1:0] {
    INIT      = 3'd0,
    MENU      = 3'd1,
    FREE_PLAY = 3'd2,
    AUTO_PLAY = 3'd3,
    LEARN     = 3'd4
  } top_state_e;

  typedef logic [15:0][7:0] screen_text_t;
  typedef logic [7:0][7:0]  seg_text_t;

  typedef struct packed {
    logic [3:0] arrow_keys;
    logic [7:0] note_keys;
  } user_input_t;

  // state is a raw field so a page can request an out-of-range slot.
  typedef struct packed {
    screen_text_t      text;
    seg_text_t         seg;
    logic [StateW-1:0] state;
  } program_output_t;

  localparam screen_text_t BlankText = {16{8'h20}};
  localparam seg_text_t    BlankSeg  = {8{8'h20}};

  localparam logic [3:0] KeyRight = 4'b1000;

  function automatic program_output_t blank_output(input top_state_e st);
    program_output_t o;
    o.text  = BlankText;
    o.seg   = BlankSeg;
    o.state = st;
    return o;
  endfunction

endpackage

// File: rtl/page_scheduler.sv
// Top-level page sequencer.
// Tracks the active page, routes user input only to it, registers its display output and
// performs a clean switch (blank, reset target page, settle) when the active page requests
// a new state.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   user_in       decoded user input
//   page_out      outputs of every page module
//   page_user_in  per-page gated input, zero for all but the armed active page
//   page_rst      per-page synchronous reset pulse
//   disp_out      registered text/seg/state for the display drivers
//   cur_state     active page
//   switching     high while not in the run phase
//   bad_req       one-cycle pulse (registered) after an out-of-range request
module page_scheduler
  import page_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PAGES    = 5,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  user_input_t          user_in,
  input  program_output_t      page_out     [NUM_PAGES],
  output user_input_t          page_user_in [NUM_PAGES],
  output logic [NUM_PAGES-1:0] page_rst,
  output program_output_t      disp_out,
  output top_state_e           cur_state,
  output logic                 switching,
  output logic                 bad_req
);

  localparam int unsigned CntW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [1:0] {PhRun, PhBlank, PhKick, PhSettle} phase_e;

  phase_e          phase_q, phase_d;
  top_state_e      tgt_q, tgt_d;
  top_state_e      cur_q, cur_d;
  logic            kick_all_q, kick_all_d;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  program_output_t disp_q, disp_d;
  logic            bad_req_q, bad_req_d;

  logic [StateW-1:0] req;

  always_comb begin
    phase_d    = phase_q;
    tgt_d      = tgt_q;
    cur_d      = cur_q;
    kick_all_d = kick_all_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    disp_d     = blank_output(cur_q);
    bad_req_d  = 1'b0;
    page_rst   = '0;
    req        = page_out[cur_q].state;

    unique case (phase_q)
      PhRun: begin
        disp_d = page_out[cur_q];
        // Key-release lockout: the press that caused the switch must be released first.
        if (!armed_q && (user_in.arrow_keys == 4'b0000)) begin
          armed_d = 1'b1;
        end
        if (req != cur_q) begin
          if (32'(req) >= NUM_PAGES) begin
            bad_req_d = 1'b1;
          end else begin
            tgt_d   = top_state_e'(req);
            cnt_d   = CntW'(BLANK_CYCLES - 1);
            phase_d = PhBlank;
            // Blank from the first switching cycle rather than one cycle late.
            disp_d  = blank_output(cur_q);
          end
        end
      end
      PhBlank: begin
        if (cnt_q == '0) begin
          phase_d = PhKick;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      PhKick: begin
        if (kick_all_q) begin
          page_rst = '1;
        end else begin
          page_rst = NUM_PAGES'(1) << tgt_q;
        end
        kick_all_d = 1'b0;
        phase_d    = PhSettle;
      end
      PhSettle: begin
        cur_d   = tgt_q;
        armed_d = 1'b0;
        phase_d = PhRun;
      end
      default: phase_d = PhKick;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PAGES; i++) begin
      page_user_in[i] = '0;
      if ((phase_q == PhRun) && armed_q && (32'(cur_q) == i)) begin
        page_user_in[i] = user_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PhKick;
      tgt_q      <= INIT;
      cur_q      <= INIT;
      kick_all_q <= 1'b1;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= blank_output(INIT);
      bad_req_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      tgt_q      <= tgt_d;
      cur_q      <= cur_d;
      kick_all_q <= kick_all_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      bad_req_q  <= bad_req_d;
    end
  end

  assign disp_out  = disp_q;
  assign cur_state = cur_q;
  assign switching = (phase_q != PhRun);
  assign bad_req   = bad_req_q;

endmodule

// File: tb/tb_page_scheduler.sv
// Self-checking bench for page_scheduler: a per-cycle vector table covering reset release,
// a switch with key lockout, ignored requests, an out-of-range request and reset during
// blanking, followed by a hand-written bounded switch sequence.
module tb_page_scheduler;
  import page_scheduler_pkg::*;

  localparam int NP     = 5;
  localparam int NBLANK = 4;
  localparam int DBlank = 7;  // expected display code meaning "blank"
  localparam int NoReq  = 7;  // no page overrides its state

  logic            clk;
  logic            rst;
  user_input_t     user_in;
  program_output_t page_out     [NP];
  user_input_t     page_user_in [NP];
  logic [NP-1:0]   page_rst;
  program_output_t disp_out;
  top_state_e      cur_state;
  logic            switching;
  logic            bad_req;

  page_scheduler #(
    .NUM_PAGES   (NP),
    .BLANK_CYCLES(NBLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .user_in     (user_in),
    .page_out    (page_out),
    .page_user_in(page_user_in),
    .page_rst    (page_rst),
    .disp_out    (disp_out),
    .cur_state   (cur_state),
    .switching   (switching),
    .bad_req     (bad_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [3:0]    arrow;
    int            rp;     // page whose state is overridden
    logic [2:0]    rv;     // overriding state value
    logic [2:0]    cur;
    logic          sw;
    logic [NP-1:0] prst;
    logic          bad;
    logic          pui;    // active page receives user_in
    int            disp;   // page index shown, or DBlank
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  int applied;
  int miscompares;

  function automatic vec_t mk(logic r, logic [3:0] a, int rp, logic [2:0] rv, logic [2:0] c,
                              logic s, logic [NP-1:0] p, logic b, logic u, int d);
    vec_t v;
    v.rst = r; v.arrow = a; v.rp = rp; v.rv = rv; v.cur = c;
    v.sw = s; v.prst = p; v.bad = b; v.pui = u; v.disp = d;
    return v;
  endfunction

  function automatic screen_text_t page_text(int i);
    return {16{8'(8'h41 + i)}};
  endfunction

  task automatic set_pages(input int rp, input logic [2:0] rv);
    for (int i = 0; i < NP; i++) begin
      page_out[i].text  = page_text(i);
      page_out[i].seg   = {8{8'(8'h30 + i)}};
      page_out[i].state = 3'(i);
      if (i == rp) page_out[i].state = rv;
    end
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic disp_ok;
    check("cur_state", idx, 32'(cur_state), 32'(v.cur));
    check("switching", idx, 32'(switching), 32'(v.sw));
    check("page_rst", idx, 32'(page_rst), 32'(v.prst));
    check("bad_req", idx, 32'(bad_req), 32'(v.bad));
    for (int i = 0; i < NP; i++) begin
      check("page_user_in", idx, 32'(page_user_in[i]),
            (v.pui && (i == int'(v.cur))) ? 32'(user_in) : 32'd0);
    end
    if (v.disp == DBlank) begin
      disp_ok = (disp_out.text == BlankText) && (disp_out.seg == BlankSeg);
    end else begin
      disp_ok = (disp_out.text == page_text(v.disp));
    end
    check("disp_out", idx, 32'(disp_ok), 32'd1);
  endtask

  initial begin
    int sw_cycles;
    logic [NP-1:0] prst_seen;

    applied     = 0;
    miscompares = 0;
    rst         = 1'b1;
    user_in     = '{arrow_keys: 4'b0000, note_keys: 8'h5A};
    set_pages(NoReq, 3'd0);

    //          rst  arrow     rp     rv    cur   sw   prst      bad  pui  disp
    vecs[0]  = mk(1, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b11111, 0, 0, DBlank);
    vecs[1]  = mk(1, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b11111, 0, 0, DBlank);
    vecs[2]  = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b11111, 0, 0, DBlank);  // kick all
    vecs[3]  = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);  // settle
    vecs[4]  = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 0, 5'b00000, 0, 0, DBlank);  // run, unarmed
    vecs[5]  = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 0, 5'b00000, 0, 1, 0);
    vecs[6]  = mk(0, KeyRight, 0,    3'd1, 3'd0, 0, 5'b00000, 0, 1, 0);       // INIT -> MENU
    vecs[7]  = mk(0, KeyRight, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);
    vecs[8]  = mk(0, KeyRight, 0,    3'd3, 3'd0, 1, 5'b00000, 0, 0, DBlank);  // ignored
    vecs[9]  = mk(0, KeyRight, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);
    vecs[10] = mk(0, KeyRight, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);
    vecs[11] = mk(0, KeyRight, NoReq, 3'd0, 3'd0, 1, 5'b00010, 0, 0, DBlank);  // kick MENU
    vecs[12] = mk(0, KeyRight, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);  // settle
    vecs[13] = mk(0, KeyRight, NoReq, 3'd0, 3'd1, 0, 5'b00000, 0, 0, DBlank);
    vecs[14] = mk(0, KeyRight, NoReq, 3'd0, 3'd1, 0, 5'b00000, 0, 0, 1);       // lockout
    vecs[15] = mk(0, 4'b0000, NoReq, 3'd0, 3'd1, 0, 5'b00000, 0, 0, 1);       // release
    vecs[16] = mk(0, KeyRight, NoReq, 3'd0, 3'd1, 0, 5'b00000, 0, 1, 1);       // passes
    vecs[17] = mk(0, 4'b0000, 2,     3'd4, 3'd1, 0, 5'b00000, 0, 1, 1);       // inactive req
    vecs[18] = mk(0, 4'b0000, 2,     3'd4, 3'd1, 0, 5'b00000, 0, 1, 1);
    vecs[19] = mk(0, 4'b0000, 1,     3'd7, 3'd1, 0, 5'b00000, 0, 1, 1);       // bad req
    vecs[20] = mk(0, 4'b0000, NoReq, 3'd0, 3'd1, 0, 5'b00000, 1, 1, 1);
    vecs[21] = mk(0, 4'b0000, NoReq, 3'd0, 3'd1, 0, 5'b00000, 0, 1, 1);
    vecs[22] = mk(0, 4'b0000, 1,     3'd3, 3'd1, 0, 5'b00000, 0, 1, 1);       // MENU -> AUTO
    vecs[23] = mk(0, 4'b0000, NoReq, 3'd0, 3'd1, 1, 5'b00000, 0, 0, DBlank);
    vecs[24] = mk(1, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b11111, 0, 0, DBlank);  // rst in blank
    vecs[25] = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b11111, 0, 0, DBlank);
    vecs[26] = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 1, 5'b00000, 0, 0, DBlank);
    vecs[27] = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 0, 5'b00000, 0, 0, DBlank);
    vecs[28] = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 0, 5'b00000, 0, 1, 0);
    vecs[29] = mk(0, 4'b0000, NoReq, 3'd0, 3'd0, 0, 5'b00000, 0, 1, 0);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst = vecs[k].rst;
      user_in.arrow_keys = vecs[k].arrow;
      set_pages(vecs[k].rp, vecs[k].rv);
      #1;
      check_vec(k, vecs[k]);
      applied++;
    end

    // Full switch INIT -> LEARN: non-run time must be BLANK_CYCLES + 2 and only LEARN kicked.
    @(negedge clk);
    user_in.arrow_keys = 4'b0000;
    set_pages(0, 3'd4);
    @(negedge clk);
    set_pages(NoReq, 3'd0);
    sw_cycles = 0;
    prst_seen = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!switching) break;
      sw_cycles++;
      prst_seen |= page_rst;
      @(negedge clk);
    end
    check("switch_len", NV, 32'(sw_cycles), 32'(NBLANK + 2));
    check("switch_kick", NV, 32'(prst_seen), 32'(5'b10000));
    check("switch_cur", NV, 32'(cur_state), 32'(LEARN));
    @(negedge clk);
    #1;
    check("switch_disp", NV, 32'(disp_out.text == page_text(4)), 32'd1);
    applied++;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
